exu_seq: RTL and testbench

EXU_SEQ -- requirements
Module: exu_seq

---
 rtl/exu_seq.sv | 71 +++++++
 tb/tb_exu_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/exu_seq.sv
// exu_seq: IDLE/EXEC/MEM/WB/HALT instruction sequencer with optional EXU_SEQ_MEM_TMO_EN watchdog; ports: clk/rst, id_valid/id_ready handshake, class flags, alu_result, mem_req/mem_wen/mem_ack, rf_wen/pc_wen/pc_sel, halt, inst_cnt
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
module exu_seq #(
  parameter int TMO_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  is_branch,
  input  logic                  is_jump,
  input  logic                  is_ebreak,
  input  logic [`ISA_WIDTH-1:0] alu_result,
  output logic                  mem_req,
  output logic                  mem_wen,
  input  logic                  mem_ack,
  output logic                  rf_wen,
  output logic                  pc_wen,
  output logic                  pc_sel,
  output logic                  halt,
  output logic [31:0]           inst_cnt
);
  typedef enum logic [2:0] {IDLE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nx;
  logic ld, st, br, jp, taken, tmo;
  logic unused_alu;
  assign unused_alu = ^alu_result[`ISA_WIDTH-1:1];
`ifdef EXU_SEQ_MEM_TMO_EN
  logic [TMO_W-1:0] wd;
  always_ff @(posedge clk)
    wd <= (rst || state != MEM) ? '0 : wd + 1'b1;
  assign tmo = wd == {{(TMO_W-1){1'b1}}, 1'b0};
`else
  logic unused_tmo;
  assign unused_tmo = TMO_W > 0;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = id_valid ? (is_ebreak ? HALT : EXEC) : IDLE;
      EXEC:    state_nx = (ld | st) ? MEM : WB;
      MEM:     state_nx = mem_ack ? WB : (tmo ? HALT : MEM);
      WB:      state_nx = IDLE;
      default: state_nx = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {ld, st, br, jp, taken} <= '0;
      inst_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && id_valid) {ld, st, br, jp} <= {is_load, is_store, is_branch, is_jump};
      if (state == EXEC) taken <= br & alu_result[0];
      if (state == WB) inst_cnt <= inst_cnt + 32'd1;
    end
  end
  assign id_ready = state == IDLE;
  assign mem_req  = state == MEM;
  assign mem_wen  = mem_req & st;
  assign pc_wen   = state == WB;
  assign rf_wen   = pc_wen & ~(st | br);
  assign pc_sel   = pc_wen & (jp | (br & taken));
  assign halt     = state == HALT;
endmodule

// File: tb/tb_exu_seq.sv
// tb_exu_seq: randomized scoreboard bench for exu_seq
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
module tb_exu_seq;
  localparam int TW = 4;
  logic clk = 0, rst = 1, id_valid = 0, mem_ack = 0;
  logic is_load = 0, is_store = 0, is_branch = 0, is_jump = 0, is_ebreak = 0;
  logic [`ISA_WIDTH-1:0] alu_result = '0;
  logic id_ready, mem_req, mem_wen, rf_wen, pc_wen, pc_sel, halt;
  logic [31:0] inst_cnt;
  exu_seq #(.TMO_W(TW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump), .is_ebreak(is_ebreak),
    .alu_result(alu_result), .mem_req(mem_req), .mem_wen(mem_wen), .mem_ack(mem_ack),
    .rf_wen(rf_wen), .pc_wen(pc_wen), .pc_sel(pc_sel), .halt(halt), .inst_cnt(inst_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {logic rf; logic sel; logic [31:0] cnt; int mem; logic wen;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, mcnt = 0;
  logic wen_seen = 0;
  logic [31:0] model_cnt = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    check("rst_id_ready", id_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_pc_wen", pc_wen, 0);
    check("rst_pc_sel", pc_sel, 0);
    check("rst_halt", halt, 0);
    check("rst_inst_cnt", inst_cnt, 0);
  endtask
  // cls: 0 alu, 1 load, 2 store, 3 branch, 4 jump, 5 ebreak
  task automatic issue(input int cls, input logic alu0, input int n);
    int w = 0;
    while (!id_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("id_ready_wait", id_ready, 1);
    id_valid = 1;
    is_load = cls == 1;
    is_store = cls == 2;
    is_branch = cls == 3;
    is_jump = cls == 4;
    is_ebreak = cls == 5;
    alu_result = `ISA_WIDTH'($urandom);
    alu_result[0] = alu0;
    if (cls != 5) begin
      q.push_back('{rf: !(cls == 2 || cls == 3), sel: cls == 4 || (cls == 3 && alu0),
                    cnt: model_cnt, mem: n, wen: cls == 2});
      model_cnt++;
    end
    @(posedge clk);
    #1;
    id_valid = 0;
    {is_load, is_store, is_branch, is_jump, is_ebreak} = '0;
  endtask
  task automatic complete(input int n);
    int lat = 0, m = 0;
    while (!pc_wen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (mem_req) begin
        m++;
        mem_ack = m == n;
      end else mem_ack = 1'($urandom_range(0, 1));
    end
    mem_ack = 0;
    check("latency", lat, 2 + n);
    @(negedge clk);
    check("ready_after_wb", id_ready, 1);
    check("inst_cnt_after_wb", inst_cnt, model_cnt);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (pc_wen) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: got writeback expected none");
        end else begin
          e = q.pop_front();
          check("wb_rf_wen", rf_wen, e.rf);
          check("wb_pc_sel", pc_sel, e.sel);
          check("wb_inst_cnt", inst_cnt, e.cnt);
          check("wb_mem_cycles", mcnt, e.mem);
          check("wb_mem_wen", wen_seen, e.wen);
        end
        mcnt = 0;
        wen_seen = 0;
      end else if (mem_req) begin
        mcnt++;
        wen_seen = wen_seen | mem_wen;
      end
      if (id_ready) begin
        mcnt = 0;
        wen_seen = 0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int cls, n, w, m;
    do_reset();
    issue(0, 1'($urandom), 0); complete(0);
    issue(3, 1, 0); complete(0);
    issue(3, 0, 0); complete(0);
    issue(2, 0, 4); complete(4);
    issue(4, 0, 0); complete(0);
    issue(1, 1, 1); complete(1);
    for (int i = 0; i < 40; i++) begin
      cls = $urandom_range(0, 4);
      n = (cls == 1 || cls == 2) ? $urandom_range(1, 6) : 0;
      issue(cls, 1'($urandom), n);
      complete(n);
    end
`ifdef EXU_SEQ_MEM_TMO_EN
    issue(1, 0, 15); complete(15);
`else
    issue(1, 0, 40); complete(40);
`endif
    issue(1, 0, 0);
    mem_ack = 0;
    repeat (3) @(negedge clk);
    check("mid_mem_req", mem_req, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    check("mid_rst_id_ready", id_ready, 1);
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_inst_cnt", inst_cnt, 0);
    check("mid_rst_rf_wen", rf_wen, 0);
    repeat (3) @(negedge clk);
    issue(0, 0, 0); complete(0);
    issue(5, 0, 0);
    @(negedge clk);
    check("halt_set", halt, 1);
    check("halt_id_ready", id_ready, 0);
    for (int i = 0; i < 5; i++) begin
      id_valid = 1;
      @(negedge clk);
      check("halt_sticky", halt, 1);
      check("halt_no_ready", id_ready, 0);
      check("halt_no_pc_wen", pc_wen, 0);
      check("halt_no_mem_req", mem_req, 0);
    end
    id_valid = 0;
    do_reset();
`ifdef EXU_SEQ_MEM_TMO_EN
    issue(1, 0, 0);
    m = 0;
    w = 0;
    while (!halt && w < 100) begin
      @(negedge clk);
      w++;
      if (mem_req) m++;
    end
    check("tmo_mem_cycles", m, 15);
    check("tmo_halt", halt, 1);
    check("tmo_inst_cnt", inst_cnt, model_cnt - 1);
    q.delete();
    do_reset();
`endif
    issue(0, 0, 0); complete(0);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
